window_gen_55: RTL and testbench
================================

Name: window_gen_55

Overview:
- Upstream feeder for the 5x5 binary-weight convolution stage: converts a raster-order 8-bit pixel stream into 5x5 sliding windows.
- Valid-only windows: no padding, stride 1.
- Each output window is packed exactly as the conv stage's `idata` expects, so `ovalid`/`odata` connect directly to its `ivalid`/`idata`.
- Holds 4 image rows in line buffers plus a 5x5 register window; no backpressure, because the conv stage accepts one window per cycle.

Parameters:
- DATA_WIDTH, 8, pixel width in bits.
- IMG_W, 28, image width in pixels; legal range is >= 5.
- IMG_H, 28, image height in pixels; legal range is >= 5.

Ports:
- clk  input  1  single clock; all state updates on its rising edge.
- rst  input  1  asynchronous, active-high reset.
- ivalid  input  1  `idata` carries the next pixel in raster order (row-major, left to right).
- idata  input  DATA_WIDTH  pixel value, unsigned.
- ovalid  output  1  `odata` holds a complete 5x5 window; asserted for one cycle per window.
- odata  output  25*DATA_WIDTH  window; element i = r*5+c occupies `[i*DATA_WIDTH +: DATA_WIDTH]`.
- oframe_done  output  1  one-cycle pulse, coincident with the `ovalid` of the last window of a frame.

Behaviour:
- Reset (async assert, sync release):
  - `ovalid`=0, `odata`=0, `oframe_done`=0.
  - col_cnt=0, row_cnt=0; window registers cleared.
  - Line-buffer contents need not be cleared.
- Window packing:
  - r=0 is the top (oldest) row; c=0 is the leftmost (oldest) column.
  - Element 24 is the pixel just accepted.
- Counters:
  - col_cnt (0..IMG_W-1) and row_cnt (0..IMG_H-1) advance only on `ivalid`.
  - col wraps to 0 and increments row.
  - At (IMG_H-1, IMG_W-1) both wrap to 0, and the next pixel starts a new frame.
- Line buffers:
  - 4 buffers, depth IMG_W, shared address = col_cnt.
  - On `ivalid` at column x: read lb0..lb3[x] (rows y-4..y-1); write lb3[x]<=lb2[x], lb2<=lb1, lb1<=lb0, lb0<=idata.
  - Column vector shifted into the window = {lb3[x], lb2[x], lb1[x], lb0[x], idata}, ordered r=0..4.
- Window: on `ivalid`, the 5x5 registers shift left one column and the new column enters at c=4.
- Output timing:
  - `ovalid`=1 in the cycle after an accepted pixel with row_cnt>=4 and col_cnt>=4; otherwise 0.
  - Latency is exactly 1 clock from that pixel.
  - `odata` is registered and holds its value when `ovalid`=0.
- Window count: (IMG_H-4)*(IMG_W-4) windows per frame.
- Stalls: gaps in `ivalid` (any length) freeze all state; output content is identical to gap-free input.
- Row start: windows at col_cnt<4 are never emitted, so stale columns from the previous row cannot leak.
- Frame start:
  - Rows 0..3 of a new frame emit nothing.
  - Previous-frame line-buffer data is fully overwritten before first use; back-to-back frames need no idle cycle.
- Reset mid-frame: the next pixel after release is treated as (0,0) and no partial window is emitted.
- `oframe_done` asserts together with `ovalid` for the window ending at pixel (IMG_H-1, IMG_W-1).

Decomposition:
- Shared package: DATA_WIDTH default, the KERNEL=5 constant, and a window-index function idx(r,c)=r*5+c that is shared with the conv stage.
- One sub-module: `line_buffer`.
  - Parameters DATA_WIDTH and DEPTH.
  - Single read/write address, read-before-write in the same cycle, with a write enable.
  - Instantiated 4 times.
  - Inferable as distributed RAM or flops.
- Counters, window registers and output logic stay in the top.

Test Plan:
- IMG_W=8, IMG_H=6, pixel value = row*8+col, `ivalid` held high: the first `ovalid` comes 1 cycle after pixel #36. That `odata` has element r*5+c = 8r+c, e.g. element 0=0, 4=4, 5=8, 24=36. Exactly 8 windows are produced, and `oframe_done` pulses only with the 8th window, whose element 24=47.
- Same frame, random 0-3 cycle gaps between pixels: the sequence of 8 `odata` values matches the gap-free run bit-exactly, each `ovalid` arrives 1 cycle after its triggering pixel, and there is no `ovalid` during gaps.
- Chained with the conv stage, weight=25'h1FFFFFF, same frame: first `dout` = 450 (sum of 8r+c over the 5x5); the second window's `dout` = 475.
- Two back-to-back frames with no idle cycles; frame 2 pixel value = 100+row*8+col: frame-2 window 0 element 0=100 and element 24=136, with no window emitted during frame-2 rows 0-3.
- Assert `rst` after 20 pixels, release, then send a full frame: `ovalid` stays 0 until 1 cycle after the 37th post-reset pixel, and that window equals the first-scenario window. Outputs read 0 while `rst` is high.
- IMG_W=5, IMG_H=5 (minimum size): exactly one window, 1 cycle after pixel #24, with `oframe_done`=1 in the same cycle.

Source files
------------

// File: rtl/window_gen_55_pkg.sv
// Shared constants and window-index helper for the 5x5 window generator and the conv stage.
package window_gen_55_pkg;

    localparam int DATA_WIDTH_DEF = 8;
    localparam int KERNEL         = 5;
    localparam int NUM_LB         = KERNEL - 1;

    function automatic int idx(input int r, input int c);
        return r * KERNEL + c;
    endfunction

endpackage

// File: rtl/window_gen_55_line_buffer.sv
// One image-row line buffer: shared address, combinational read of the old word, write on enable.
module line_buffer #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 28,
    localparam int AW        = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic                  clk,
    input  logic                  we_i,
    input  logic [AW-1:0]         addr_i,
    input  logic [DATA_WIDTH-1:0] wdata_i,
    output logic [DATA_WIDTH-1:0] rdata_o
);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];

    // Read returns the word stored before this cycle's write lands.
    assign rdata_o = mem_q[addr_i];

    // Storage update; contents are deliberately not reset.
    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[addr_i] <= wdata_i;
        end
    end

endmodule

// File: rtl/window_gen_55.sv
// Raster pixel stream to 5x5 valid-only sliding windows, one registered window per qualifying pixel.
module window_gen_55
    import window_gen_55_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int IMG_W      = 28,
    parameter int IMG_H      = 28
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                ivalid,
    input  logic [DATA_WIDTH-1:0]               idata,
    output logic                                ovalid,
    output logic [KERNEL*KERNEL*DATA_WIDTH-1:0] odata,
    output logic                                oframe_done
);

    localparam int CW = $clog2(IMG_W);
    localparam int RW = $clog2(IMG_H);
    localparam int OW = KERNEL * KERNEL * DATA_WIDTH;

    localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
    localparam logic [CW-1:0] COL_MIN  = CW'(KERNEL - 1);
    localparam logic [CW-1:0] COL_ONE  = CW'(1);
    localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);
    localparam logic [RW-1:0] ROW_MIN  = RW'(KERNEL - 1);
    localparam logic [RW-1:0] ROW_ONE  = RW'(1);

    logic [CW-1:0]         col_q, col_d;
    logic [RW-1:0]         row_q, row_d;
    logic [DATA_WIDTH-1:0] win_q [KERNEL][KERNEL];
    logic [DATA_WIDTH-1:0] win_d [KERNEL][KERNEL];
    logic                  ovalid_q, ovalid_d;
    logic                  done_q, done_d;
    logic [OW-1:0]         odata_q, odata_d;

    logic [DATA_WIDTH-1:0] lb_rd_s  [NUM_LB];
    logic [DATA_WIDTH-1:0] lb_wr_s  [NUM_LB];
    logic [DATA_WIDTH-1:0] col_vec_s[KERNEL];

    // Line-buffer cascade and the new column: lb3 is the oldest row, idata the newest.
    always_comb begin
        lb_wr_s[0] = idata;
        for (int i = 1; i < NUM_LB; i++) begin
            lb_wr_s[i] = lb_rd_s[i-1];
        end
        for (int r = 0; r < NUM_LB; r++) begin
            col_vec_s[r] = lb_rd_s[NUM_LB-1-r];
        end
        col_vec_s[KERNEL-1] = idata;
    end

    for (genvar gi = 0; gi < NUM_LB; gi++) begin : g_lb
        line_buffer #(
            .DATA_WIDTH(DATA_WIDTH),
            .DEPTH     (IMG_W)
        ) u_lb (
            .clk    (clk),
            .we_i   (ivalid),
            .addr_i (col_q),
            .wdata_i(lb_wr_s[gi]),
            .rdata_o(lb_rd_s[gi])
        );
    end

    // Next state: window shift, raster counters and the emit decision for the accepted pixel.
    always_comb begin
        win_d    = win_q;
        col_d    = col_q;
        row_d    = row_q;
        ovalid_d = 1'b0;
        done_d   = 1'b0;
        odata_d  = odata_q;
        if (ivalid) begin
            for (int r = 0; r < KERNEL; r++) begin
                for (int c = 0; c < KERNEL - 1; c++) begin
                    win_d[r][c] = win_q[r][c+1];
                end
                win_d[r][KERNEL-1] = col_vec_s[r];
            end
            if (col_q == COL_LAST) begin
                col_d = {CW{1'b0}};
                if (row_q == ROW_LAST) begin
                    row_d = {RW{1'b0}};
                end else begin
                    row_d = row_q + ROW_ONE;
                end
            end else begin
                col_d = col_q + COL_ONE;
            end
            // Columns 0..3 of a row still hold the previous row's tail, so they never emit.
            ovalid_d = (row_q >= ROW_MIN) && (col_q >= COL_MIN);
            done_d   = ovalid_d && (row_q == ROW_LAST) && (col_q == COL_LAST);
            if (ovalid_d) begin
                for (int r = 0; r < KERNEL; r++) begin
                    for (int c = 0; c < KERNEL; c++) begin
                        odata_d[idx(r, c)*DATA_WIDTH +: DATA_WIDTH] = win_d[r][c];
                    end
                end
            end else begin
                odata_d = odata_q;
            end
        end else begin
            ovalid_d = 1'b0;
        end
    end

    // State and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            col_q    <= {CW{1'b0}};
            row_q    <= {RW{1'b0}};
            ovalid_q <= 1'b0;
            done_q   <= 1'b0;
            odata_q  <= {OW{1'b0}};
            for (int r = 0; r < KERNEL; r++) begin
                for (int c = 0; c < KERNEL; c++) begin
                    win_q[r][c] <= {DATA_WIDTH{1'b0}};
                end
            end
        end else begin
            col_q    <= col_d;
            row_q    <= row_d;
            ovalid_q <= ovalid_d;
            done_q   <= done_d;
            odata_q  <= odata_d;
            win_q    <= win_d;
        end
    end

    assign ovalid      = ovalid_q;
    assign odata       = odata_q;
    assign oframe_done = done_q;

endmodule

// File: tb/tb_window_gen_55.sv
// Bench for window_gen_55: image-array model checked every cycle, plus hand-computed window values.
module tb_window_gen_55;

    localparam int OW = 200;

    logic          clk;
    logic          rst;
    logic          iv_a, iv_b;
    logic [7:0]    d_a, d_b;
    logic          ovalid_a, ovalid_b, done_a, done_b;
    logic [OW-1:0] odata_a, odata_b;

    int n_checks = 0;
    int n_errors = 0;

    // Model state per DUT (0: 8x6, 1: 5x5)
    logic [7:0]    img   [2][6][8];
    int            npix  [2];
    logic          exp_v [2];
    logic          exp_dn[2];
    logic [OW-1:0] exp_d [2];

    logic [OW-1:0] wins_a[$];
    logic [OW-1:0] wins_b[$];
    logic [OW-1:0] ref_w [$];
    int            frames_a = 0;
    int            frames_b = 0;

    window_gen_55 #(.DATA_WIDTH(8), .IMG_W(8), .IMG_H(6)) dut_a (
        .clk(clk), .rst(rst), .ivalid(iv_a), .idata(d_a),
        .ovalid(ovalid_a), .odata(odata_a), .oframe_done(done_a)
    );

    window_gen_55 #(.DATA_WIDTH(8), .IMG_W(5), .IMG_H(5)) dut_b (
        .clk(clk), .rst(rst), .ivalid(iv_b), .idata(d_b),
        .ovalid(ovalid_b), .odata(odata_b), .oframe_done(done_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [OW-1:0] act, input logic [OW-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic int elem(input logic [OW-1:0] w, input int i);
        return int'(w[i*8 +: 8]);
    endfunction

    function automatic int wsum(input logic [OW-1:0] w);
        int s = 0;
        for (int i = 0; i < 25; i++) s += int'(w[i*8 +: 8]);
        return s;
    endfunction

    // Window at (y,x) is the 5x5 block of the stored image ending at that pixel.
    task automatic model_step(input int id, input int w, input int h,
                              input logic r, input logic v, input logic [7:0] d);
        int y, x;
        logic [OW-1:0] t;
        if (r) begin
            exp_v[id] = 1'b0; exp_dn[id] = 1'b0; exp_d[id] = '0; npix[id] = 0;
        end else begin
            exp_v[id] = 1'b0; exp_dn[id] = 1'b0;
            if (v) begin
                y = npix[id] / w;
                x = npix[id] % w;
                img[id][y][x] = d;
                if (y >= 4 && x >= 4) begin
                    t = '0;
                    for (int rr = 0; rr < 5; rr++)
                        for (int cc = 0; cc < 5; cc++)
                            t[(rr*5+cc)*8 +: 8] = img[id][y-4+rr][x-4+cc];
                    exp_d[id]  = t;
                    exp_v[id]  = 1'b1;
                    exp_dn[id] = (y == h-1) && (x == w-1);
                end
                npix[id] = (npix[id] + 1) % (w*h);
            end
        end
    endtask

    // Model update at the edge, compare 1 time unit later.
    always @(posedge clk) begin : chk_a
        model_step(0, 8, 6, rst, iv_a, d_a);
        #1;
        check("a_ovalid", OW'(ovalid_a), OW'(exp_v[0]));
        check("a_frame_done", OW'(done_a), OW'(exp_dn[0]));
        check("a_odata", odata_a, exp_d[0]);
        if (ovalid_a) wins_a.push_back(odata_a);
        if (done_a) frames_a++;
    end

    always @(posedge clk) begin : chk_b
        model_step(1, 5, 5, rst, iv_b, d_b);
        #1;
        check("b_ovalid", OW'(ovalid_b), OW'(exp_v[1]));
        check("b_frame_done", OW'(done_b), OW'(exp_dn[1]));
        check("b_odata", odata_b, exp_d[1]);
        if (ovalid_b) wins_b.push_back(odata_b);
        if (done_b) frames_b++;
    end

    task automatic send_a(input int base, input int maxgap, input int count);
        int g;
        for (int n = 0; n < count; n++) begin
            iv_a = 1'b1;
            d_a  = 8'(base + (n / 8) * 8 + (n % 8));
            @(negedge clk);
            g = (maxgap > 0) ? int'($urandom_range(maxgap, 0)) : 0;
            if (g > 0) begin
                iv_a = 1'b0;
                repeat (g) @(negedge clk);
            end
        end
    endtask

    task automatic idle(input int n);
        iv_a = 1'b0;
        iv_b = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    initial begin
        rst = 1'b0; iv_a = 1'b0; iv_b = 1'b0; d_a = 8'd0; d_b = 8'd0;
        #2 rst = 1'b1;
        repeat (3) @(negedge clk);
        check("reset_ovalid", OW'(ovalid_a), OW'(1'b0));
        check("reset_odata", odata_a, '0);
        rst = 1'b0;

        // Gap-free frame
        wins_a.delete(); frames_a = 0;
        send_a(0, 0, 48);
        idle(3);
        check("s1_window_count", OW'(wins_a.size()), OW'(8));
        check("s1_frame_done_count", OW'(frames_a), OW'(1));
        if (wins_a.size() == 8) begin
            check("s1_w0_e0", OW'(elem(wins_a[0], 0)), OW'(0));
            check("s1_w0_e4", OW'(elem(wins_a[0], 4)), OW'(4));
            check("s1_w0_e5", OW'(elem(wins_a[0], 5)), OW'(8));
            check("s1_w0_e24", OW'(elem(wins_a[0], 24)), OW'(36));
            check("s1_w7_e24", OW'(elem(wins_a[7], 24)), OW'(47));
            check("conv_sum_w0", OW'(wsum(wins_a[0])), OW'(450));
            check("conv_sum_w1", OW'(wsum(wins_a[1])), OW'(475));
        end
        ref_w = wins_a;

        // Same frame with random gaps
        wins_a.delete();
        send_a(0, 3, 48);
        idle(3);
        check("s2_window_count", OW'(wins_a.size()), OW'(8));
        for (int i = 0; i < 8; i++)
            if (i < wins_a.size() && i < ref_w.size())
                check("s2_window_match", wins_a[i], ref_w[i]);

        // Back-to-back frames
        wins_a.delete(); frames_a = 0;
        send_a(0, 0, 48);
        send_a(100, 0, 48);
        idle(3);
        check("s4_window_count", OW'(wins_a.size()), OW'(16));
        check("s4_frame_done_count", OW'(frames_a), OW'(2));
        if (wins_a.size() == 16) begin
            check("s4_f2w0_e0", OW'(elem(wins_a[8], 0)), OW'(100));
            check("s4_f2w0_e24", OW'(elem(wins_a[8], 24)), OW'(136));
        end

        // Reset mid-frame
        send_a(0, 0, 20);
        iv_a = 1'b0;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        check("s5_rst_ovalid", OW'(ovalid_a), OW'(1'b0));
        check("s5_rst_odata", odata_a, '0);
        rst = 1'b0;
        wins_a.delete();
        send_a(0, 0, 48);
        idle(3);
        check("s5_window_count", OW'(wins_a.size()), OW'(8));
        if (wins_a.size() > 0 && ref_w.size() > 0)
            check("s5_first_window", wins_a[0], ref_w[0]);

        // Minimum 5x5 image
        wins_b.delete(); frames_b = 0;
        for (int n = 0; n < 25; n++) begin
            iv_b = 1'b1;
            d_b  = 8'(n);
            @(negedge clk);
        end
        idle(3);
        check("s6_window_count", OW'(wins_b.size()), OW'(1));
        check("s6_frame_done_count", OW'(frames_b), OW'(1));
        if (wins_b.size() == 1) begin
            check("s6_e0", OW'(elem(wins_b[0], 0)), OW'(0));
            check("s6_e24", OW'(elem(wins_b[0], 24)), OW'(24));
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
